// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> HI/LO sequencer bundle: operation request, stall back to the
// pipeline, and the write port into the HI/LO register file.
interface muldiv_ctrl_if;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic [31:0] hi_cur_i;
    logic [31:0] lo_cur_i;
    logic        stall_o;
    logic        we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_i, a_i, b_i, cancel_i, hi_cur_i, lo_cur_i,
        input  stall_o, we_o, hi_o, lo_o
    );

    modport slave (
        input  op_i, a_i, b_i, cancel_i, hi_cur_i, lo_cur_i,
        output stall_o, we_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: single-cycle multiply, 32-step restoring divide, MTHI/MTLO
// pass-through. One write strobe per completed op; cancel aborts silently.
module muldiv_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   opa;
    logic [31:0]   opb;
    logic          sgn;
    logic          neg_q;
    logic          neg_r;
    logic [63:0]   rq;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    logic        is_mul;
    logic        is_div;
    logic        sdiv;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign is_mul = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
    assign is_div = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
    assign sdiv   = (bus.op_i == OP_DIV);
    assign a_mag  = (sdiv && bus.a_i[31]) ? (32'd0 - bus.a_i) : bus.a_i;
    assign b_mag  = (sdiv && bus.b_i[31]) ? (32'd0 - bus.b_i) : bus.b_i;

    // Multiply on 64-bit extended operands; the low 64 bits are exact for
    // both signed and unsigned forms.
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    logic signed [63:0] prod;

    assign ext_a = {{32{sgn & opa[31]}}, opa};
    assign ext_b = {{32{sgn & opb[31]}}, opb};
    assign prod  = ext_a * ext_b;

    // One restoring step: shift remainder:quotient left, trial-subtract the
    // divisor from the 33-bit partial remainder, shift in the quotient bit.
    logic [64:0] sh;
    logic        ge;
    logic [32:0] diff;
    logic [63:0] rq_nx;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign sh    = {rq, 1'b0};
    assign diff  = sh[64:32] - {1'b0, opb};
    assign ge    = (sh[64:32] >= {1'b0, opb});
    assign rq_nx = {(ge ? diff[31:0] : sh[63:32]), rq[30:0], ge};
    assign q_fin = neg_q ? (32'd0 - rq_nx[31:0])  : rq_nx[31:0];
    assign r_fin = neg_r ? (32'd0 - rq_nx[63:32]) : rq_nx[63:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            sgn    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rq     <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else if (bus.cancel_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        opa   <= bus.a_i;
                        opb   <= bus.b_i;
                        sgn   <= (bus.op_i == OP_MULT);
                        state <= MUL;
                    end else if (is_div) begin
                        if (bus.b_i == 32'd0) begin
                            res_hi <= bus.a_i;
                            res_lo <= 32'hFFFF_FFFF;
                            state  <= DONE;
                        end else begin
                            rq    <= {32'd0, a_mag};
                            opb   <= b_mag;
                            neg_q <= sdiv & (bus.a_i[31] ^ bus.b_i[31]);
                            neg_r <= sdiv & bus.a_i[31];
                            cnt   <= '0;
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    res_hi <= prod[63:32];
                    res_lo <= prod[31:0];
                    state  <= DONE;
                end
                DIV: begin
                    rq  <= rq_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        res_hi <= r_fin;
                        res_lo <= q_fin;
                        cnt    <= '0;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are combinational so the accept-cycle stall and MT writes land
    // in the same cycle the EX stage presents the op.
    always_comb begin
        bus.stall_o = 1'b0;
        bus.we_o    = 1'b0;
        bus.hi_o    = '0;
        bus.lo_o    = '0;
        if (rst && !bus.cancel_i) begin
            case (state)
                IDLE: begin
                    if (is_mul || is_div) begin
                        bus.stall_o = 1'b1;
                    end else if (bus.op_i == OP_MTHI) begin
                        bus.we_o = 1'b1;
                        bus.hi_o = bus.a_i;
                        bus.lo_o = bus.lo_cur_i;
                    end else if (bus.op_i == OP_MTLO) begin
                        bus.we_o = 1'b1;
                        bus.hi_o = bus.hi_cur_i;
                        bus.lo_o = bus.a_i;
                    end
                end
                MUL, DIV: bus.stall_o = 1'b1;
                DONE: begin
                    bus.we_o = 1'b1;
                    bus.hi_o = res_hi;
                    bus.lo_o = res_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the HI/LO register pair. It accepts multiply, divide and move-to-HI/LO operations from the EX stage. Multiply and divide are run as multi-cycle operations, with the pipeline stalled through a `stall_o` handshake. Each operation ends with exactly one write strobe, plus 64-bit result data, delivered to the HI/LO register file.

## Interface
Parameters:
- `DIV_ITERS`, default 32: number of restoring-division iterations. Fixed at the datapath width; only 32 is supported.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_i`  in  3  EX-stage operation:
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 is treated as NOP.
- `a_i`  in  32  operand A: rs, the dividend, or the MT source.
- `b_i`  in  32  operand B: rt, the divisor.
- `cancel_i`  in  1  pipeline flush; aborts any in-flight operation.
- `hi_cur_i`  in  32  current HI value from the HI/LO register file.
- `lo_cur_i`  in  32  current LO value from the HI/LO register file.
- `stall_o`  out  1  holds the EX stage and everything upstream of it.
- `we_o`  out  1  write strobe to the HI/LO register file.
- `hi_o`  out  32  HI write data.
- `lo_o`  out  32  LO write data.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - MULT/MULTU/DIV/DIVU: latch `a_i`, `b_i` and signedness. Go to MUL for multiplies, DIV for divides. Assert `stall_o` combinationally in this same cycle.
  - DIV/DIVU with `b_i` == 0: go directly to DONE. Result is HI = `a_i`, LO = 32'hFFFF_FFFF.
  - MTHI: same cycle, `we_o`=1, `hi_o`=`a_i`, `lo_o`=`lo_cur_i`. No stall, no state change.
  - MTLO: same cycle, `we_o`=1, `hi_o`=`hi_cur_i`, `lo_o`=`a_i`. No stall, no state change.
  - NOP/7: nothing happens.
- MUL:
  - One cycle. Compute the 64-bit product into a result register: signed for MULT, unsigned for MULTU.
  - Go to DONE. `stall_o`=1.
- DIV:
  - Divide on operand magnitudes (absolute value when signed). Each cycle performs one restoring shift/subtract step on a 64-bit remainder:quotient register; an iteration counter counts 0..31.
  - After iteration 31, apply signs:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Then go to DONE. `stall_o`=1 throughout.
  - Signed 0x8000_0000 / −1: quotient 0x8000_0000, remainder 0 (wraps, no trap).
- DONE:
  - `we_o`=1, `hi_o`=remainder (div) or product[63:32] (mul), `lo_o`=quotient or product[31:0].
  - `stall_o`=0.
  - Unconditionally return to IDLE. `op_i` is ignored this cycle, because it still shows the stalled instruction.
- `cancel_i`:
  - In any state it forces IDLE on the next edge. `we_o` and `stall_o` are 0 in the cycle it is high.
  - In IDLE it also blocks acceptance and any MT write.
  - It has priority over everything except reset.
- `op_i` is ignored in MUL and DIV.

## Timing
- Reset, asynchronous: state IDLE, counter 0, result registers 0.
- Reset values of outputs: `stall_o`=0, `we_o`=0, `hi_o`=0, `lo_o`=0.
- Reset asserted mid-operation discards the operation; no write occurs.
- Outputs are combinational from state and inputs:
  - `hi_o`/`lo_o` are 0 when `we_o`=0.
  - The HI/LO file captures them on the following negedge.
- Latency, counting the accept cycle as cycle 0:
  - MT ops: write in cycle 0.
  - Multiply: `stall_o` high in cycles 0–1; write in cycle 2.
  - Divide: `stall_o` high in cycles 0–32; write in cycle 33.
  - Divide-by-zero: stall in cycle 0; write in cycle 1.
- Exactly one `we_o` pulse per completed multiply/divide. No write for an aborted operation.
- Back-to-back operations: a new op can be accepted in the cycle after DONE, i.e. in IDLE.

## Test plan
- MULTU a=0xFFFF_FFFF, b=2 → `stall_o` high for 2 cycles, then one `we_o` pulse with hi=0x1, lo=0xFFFF_FFFE.
- MULT a=−3, b=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB in cycle 2.
- DIV a=−7, b=2 → stall for 33 cycles, write in cycle 33 with lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1).
- DIVU a=100, b=0 → write in cycle 1 with hi=100, lo=0xFFFF_FFFF.
- MTHI a=0x1234 with lo_cur=0xABCD, then MTLO next cycle → `we_o` high in both cycles, no stall.
  - Cycle 1 writes hi=0x1234, lo=0xABCD.
  - Cycle 2 writes lo=`a_i`.
- DIVU started, `cancel_i` pulsed at cycle 10 → no `we_o` at all, `stall_o`=0 from cycle 10, IDLE at cycle 11.
- DIVU started, `rst` pulsed low at cycle 20 → all outputs 0, no write afterward.
